// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, issues single-outstanding I-cache
// requests, absorbs stalls in a one-entry buffer and registers {instr, pc, valid}.
module fetch_stage #(
  parameter int unsigned             ADDRESS_WIDTH   = 32,
  parameter int unsigned             DATA_WIDTH      = 32,
  parameter logic [ADDRESS_WIDTH-1:0] PC_RESET        = 32'h00000000,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTRUCTION = 32'h00000013
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     STALL_FETCH_STAGE,
  input  logic                     CLEAR_FETCH_STAGE,
  input  logic                     BRANCH_TAKEN,
  input  logic [ADDRESS_WIDTH-1:0] BRANCH_ADDRESS,
  output logic [ADDRESS_WIDTH-1:0] I_CACHE_ADDRESS,
  output logic                     I_CACHE_REQUEST,
  input  logic                     I_CACHE_READY,
  input  logic [DATA_WIDTH-1:0]    I_CACHE_INSTRUCTION,
  output logic [DATA_WIDTH-1:0]    INSTRUCTION,
  output logic [ADDRESS_WIDTH-1:0] PC_OUT,
  output logic                     PC_VALID
);

  typedef enum logic {FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
  } fetch_ent_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDRESS_WIDTH-1:0] r_pending, w_pending_nxt;
  logic                     r_buf_full, w_buf_full_nxt;
  fetch_ent_t               r_buf, w_buf_nxt;
  fetch_ent_t               r_out, w_out_nxt;
  logic                     r_valid, w_valid_nxt;

  logic                     w_req;
  logic                     w_xfer;
  logic [ADDRESS_WIDTH-1:0] w_br_addr;
  logic [ADDRESS_WIDTH-1:0] w_pc_inc;
  logic                     w_hold_req;

  assign w_req      = RST_N & ~r_buf_full;
  assign w_xfer     = w_req & I_CACHE_READY;
  assign w_br_addr  = {BRANCH_ADDRESS[ADDRESS_WIDTH-1:2], 2'b00};
  assign w_pc_inc   = r_fetch_pc + ADDRESS_WIDTH'(4);
  assign w_hold_req = STALL_FETCH_STAGE | CLEAR_FETCH_STAGE;

  assign I_CACHE_REQUEST = w_req;
  assign I_CACHE_ADDRESS = r_fetch_pc;
  assign INSTRUCTION     = r_out.instr;
  assign PC_OUT          = r_out.pc;
  assign PC_VALID        = r_valid;

  // PC / state / holding buffer
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pending_nxt  = r_pending;
    w_buf_full_nxt = r_buf_full;
    w_buf_nxt      = r_buf;

    unique case (r_state)
      FETCH: begin
        if (w_xfer) begin
          if (BRANCH_TAKEN) begin
            w_fetch_pc_nxt = w_br_addr;
          end else begin
            w_fetch_pc_nxt = w_pc_inc;
            if (w_hold_req) begin
              w_buf_full_nxt = 1'b1;
              w_buf_nxt      = '{instr: I_CACHE_INSTRUCTION, pc: r_fetch_pc};
            end
          end
        end else if (BRANCH_TAKEN) begin
          // Request still open: keep the address stable and drop its reply later.
          if (w_req) begin
            w_pending_nxt = w_br_addr;
            w_state_nxt   = DISCARD;
          end else begin
            w_fetch_pc_nxt = w_br_addr;
          end
        end
      end
      DISCARD: begin
        if (w_xfer) begin
          w_fetch_pc_nxt = BRANCH_TAKEN ? w_br_addr : r_pending;
          w_state_nxt    = FETCH;
        end else if (BRANCH_TAKEN) begin
          w_pending_nxt = w_br_addr;
        end
      end
      default: w_state_nxt = FETCH;
    endcase

    if (BRANCH_TAKEN) begin
      w_buf_full_nxt = 1'b0;
    end else if (r_buf_full && !w_hold_req) begin
      w_buf_full_nxt = 1'b0;
    end
  end

  // Output registers toward decode
  always_comb begin
    w_out_nxt   = '{instr: NOP_INSTRUCTION, pc: '0};
    w_valid_nxt = 1'b0;
    if (BRANCH_TAKEN || CLEAR_FETCH_STAGE) begin
      w_out_nxt   = '{instr: NOP_INSTRUCTION, pc: '0};
      w_valid_nxt = 1'b0;
    end else if (STALL_FETCH_STAGE) begin
      w_out_nxt   = r_out;
      w_valid_nxt = r_valid;
    end else if (r_buf_full) begin
      w_out_nxt   = r_buf;
      w_valid_nxt = 1'b1;
    end else if (r_state == FETCH && w_xfer) begin
      w_out_nxt   = '{instr: I_CACHE_INSTRUCTION, pc: r_fetch_pc};
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= FETCH;
      r_fetch_pc <= PC_RESET;
      r_pending  <= PC_RESET;
      r_buf_full <= 1'b0;
      r_buf      <= '{instr: NOP_INSTRUCTION, pc: '0};
      r_out      <= '{instr: NOP_INSTRUCTION, pc: '0};
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pending  <= w_pending_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_buf      <= w_buf_nxt;
      r_out      <= w_out_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

endmodule
